// File: rtl/datapath_sequencer_pkg.sv
// datapath_sequencer_pkg
// Shared definitions for the datapath sequencer:
//   - opcode values understood by the sequencer (NOP..OUTIN)
//   - FSM state codes, kept as plain localparams so older tools and
//     netlists can read them without enum support
//   - the strobe bundle type and the opcode decode function
package datapath_sequencer_pkg;

    localparam int unsigned OP_NOP   = 0;
    localparam int unsigned OP_LDA   = 1;
    localparam int unsigned OP_LDB   = 2;
    localparam int unsigned OP_ADD   = 3;
    localparam int unsigned OP_SUB   = 4;
    localparam int unsigned OP_ACC   = 5;
    localparam int unsigned OP_OUTA  = 6;
    localparam int unsigned OP_OUTIN = 7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_TURN   = 2'd3;

    typedef struct packed {
        logic latch_a;
        logic latch_b;
        logic enable_a;
        logic enable_alu;
        logic enable_in;
        logic enable_out;
        logic add_sub;
        logic illegal;
    } strobe_t;

    // Every opcode sets add_sub (only SUB selects B-A), so AddSub is
    // reloaded on each instruction entry rather than left stale.
    // Undefined codes decode to no strobes with the illegal flag set.
    function automatic strobe_t decode_op(input int unsigned code);
        strobe_t s;
        s = '0;
        case (code)
            OP_NOP: ;
            OP_LDA: begin
                s.enable_in = 1'b1;
                s.latch_a   = 1'b1;
            end
            OP_LDB: begin
                s.enable_in = 1'b1;
                s.latch_b   = 1'b1;
            end
            OP_ADD: begin
                s.enable_alu = 1'b1;
                s.enable_out = 1'b1;
            end
            OP_SUB: begin
                s.enable_alu = 1'b1;
                s.enable_out = 1'b1;
                s.add_sub    = 1'b1;
            end
            OP_ACC: begin
                s.enable_alu = 1'b1;
                s.latch_a    = 1'b1;
            end
            OP_OUTA: begin
                s.enable_a   = 1'b1;
                s.enable_out = 1'b1;
            end
            OP_OUTIN: begin
                s.enable_in  = 1'b1;
                s.enable_out = 1'b1;
            end
            default: s.illegal = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if
// Instruction handshake plus datapath strobe bundle between an
// instruction source (master) and the sequencer (slave).
//   InstrValid/Opcode     : master -> sequencer, opcode offer
//   InstrReady            : sequencer idle, may accept
//   LatchA/LatchB         : register A / B load strobes
//   EnableA/EnableAlu/EnableIn : IB drivers (at most one at a time)
//   EnableOut             : output register load from IB
//   AddSub                : ALU mode, 0 = A+B, 1 = B-A
//   Done/IllegalOp        : retire pulse, illegal flag with it
interface datapath_sequencer_if #(
    parameter int OPW = 4
);
    logic           InstrValid;
    logic [OPW-1:0] Opcode;
    logic           InstrReady;
    logic           LatchA;
    logic           LatchB;
    logic           EnableA;
    logic           EnableAlu;
    logic           EnableIn;
    logic           EnableOut;
    logic           AddSub;
    logic           Done;
    logic           IllegalOp;

    modport master (
        output InstrValid, Opcode,
        input  InstrReady, LatchA, LatchB, EnableA, EnableAlu, EnableIn,
               EnableOut, AddSub, Done, IllegalOp
    );

    modport slave (
        input  InstrValid, Opcode,
        output InstrReady, LatchA, LatchB, EnableA, EnableAlu, EnableIn,
               EnableOut, AddSub, Done, IllegalOp
    );
endinterface

// File: rtl/datapath_sequencer.sv
// datapath_sequencer
// Control end of the A/B/ALU/in-out datapath on the 4-bit bus IB.
// Accepts one opcode over valid/ready, then runs a timed
// SETUP -> STROBE -> TURN sequence and retires with a Done pulse.
// Ports:
//   MainClock : clock, all state on rising edge
//   MainReset : synchronous active-high reset
//   bus       : datapath_sequencer_if slave modport (handshake + strobes)
// All outputs come straight from flops; next-output values are derived
// from the next state so they line up with the state they belong to.
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int OPW           = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1,
    parameter int TURN_CYCLES   = 1
) (
    input  logic                  MainClock,
    input  logic                  MainReset,
    datapath_sequencer_if.slave   bus
);

    localparam int MAX_A   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_CYC = (MAX_A > TURN_CYCLES) ? MAX_A : TURN_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The phase counter is loaded with (length-1) on state entry and
    // counts down; the phase ends when it reads zero.
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);

    logic [OPW-1:0]   opcode_in;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    strobe_t          op_q, op_d;
    strobe_t          out_q, out_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    assign opcode_in = bus.Opcode;

    // Next state, phase counter and captured decode. The opcode is only
    // looked at in IDLE, so offers while busy are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.InstrValid) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    op_d    = decode_op(32'(opcode_in));
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_TURN;
                    cnt_d   = TURN_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs. Strobes exist only in STROBE, which keeps the
    // IB drivers off during SETUP and TURN. AddSub reloads only when
    // SETUP is entered and otherwise holds.
    always_comb begin
        out_d   = '0;
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_TURN) && (cnt_d == '0);
        if (state_d == ST_STROBE) begin
            out_d = op_d;
        end
        if ((state_q == ST_IDLE) && (state_d == ST_SETUP)) begin
            out_d.add_sub = op_d.add_sub;
        end else begin
            out_d.add_sub = out_q.add_sub;
        end
        out_d.illegal = done_d && op_d.illegal;
    end

    always_ff @(posedge MainClock) begin
        if (MainReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.InstrReady = ready_q;
    assign bus.LatchA     = out_q.latch_a;
    assign bus.LatchB     = out_q.latch_b;
    assign bus.EnableA    = out_q.enable_a;
    assign bus.EnableAlu  = out_q.enable_alu;
    assign bus.EnableIn   = out_q.enable_in;
    assign bus.EnableOut  = out_q.enable_out;
    assign bus.AddSub     = out_q.add_sub;
    assign bus.Done       = done_q;
    assign bus.IllegalOp  = out_q.illegal;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer
// Two sequencer instances: dut with default timing, dut2 with
// SETUP=2 / STROBE=3 / TURN=1. Expected outputs come from a cycle-index
// model built from the opcode table and the phase lengths.
module tb_datapath_sequencer;

    logic MainClock = 1'b0;
    logic MainReset;
    int   checks   = 0;
    int   failures = 0;
    bit   inv_en   = 1'b0;

    localparam logic [9:0] IDLE_RST = 10'b1000000000;

    datapath_sequencer_if #(.OPW(4)) sif ();
    datapath_sequencer_if #(.OPW(4)) sif2 ();

    datapath_sequencer #(
        .OPW(4), .SETUP_CYCLES(1), .STROBE_CYCLES(1), .TURN_CYCLES(1)
    ) dut (
        .MainClock(MainClock),
        .MainReset(MainReset),
        .bus(sif.slave)
    );

    datapath_sequencer #(
        .OPW(4), .SETUP_CYCLES(2), .STROBE_CYCLES(3), .TURN_CYCLES(1)
    ) dut2 (
        .MainClock(MainClock),
        .MainReset(MainReset),
        .bus(sif2.slave)
    );

    always #5 MainClock = ~MainClock;

    // Observed vector: {ready, LatchA, LatchB, EnableA, EnableAlu,
    // EnableIn, EnableOut, AddSub, Done, IllegalOp}
    function automatic logic [9:0] obs(input int sel);
        if (sel == 0)
            return {sif.InstrReady, sif.LatchA, sif.LatchB, sif.EnableA, sif.EnableAlu,
                    sif.EnableIn, sif.EnableOut, sif.AddSub, sif.Done, sif.IllegalOp};
        return {sif2.InstrReady, sif2.LatchA, sif2.LatchB, sif2.EnableA, sif2.EnableAlu,
                sif2.EnableIn, sif2.EnableOut, sif2.AddSub, sif2.Done, sif2.IllegalOp};
    endfunction

    // Opcode table: {LatchA, LatchB, EnableA, EnableAlu, EnableIn, EnableOut}
    function automatic logic [5:0] spec_strobes(input int op);
        case (op)
            1:       return 6'b100010;
            2:       return 6'b010010;
            3, 4:    return 6'b000101;
            5:       return 6'b100100;
            6:       return 6'b001001;
            7:       return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    // Expected outputs k cycles after the accepting edge (k >= 1).
    function automatic logic [9:0] model(input int op, input int k,
                                         input int s, input int st, input int tu);
        int         total;
        logic       busy;
        logic [5:0] stb;
        logic       done;
        total = s + st + tu;
        busy  = (k >= 1) && (k <= total);
        stb   = ((k > s) && (k <= s + st)) ? spec_strobes(op) : 6'b0;
        done  = (k == total);
        return {!busy, stb, (op == 4), done, done && (op > 7)};
    endfunction

    task automatic checkOutput(input string tag, input logic [9:0] observed,
                               input logic [9:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [3:0] op);
        if (sel == 0) begin
            sif.InstrValid = v;
            sif.Opcode     = op;
        end else begin
            sif2.InstrValid = v;
            sif2.Opcode     = op;
        end
    endtask

    task automatic tick();
        @(posedge MainClock);
        #1;
    endtask

    // Offers op in the current (idle) cycle, then checks every cycle up
    // to and including the first idle cycle after Done. With hold_valid,
    // InstrValid stays high with a random opcode while busy.
    task automatic applyStimulus(input int sel, input int op, input int s,
                                 input int st, input int tu, input bit hold_valid);
        int total;
        total = s + st + tu;
        drive(sel, 1'b1, 4'(op));
        tick();
        for (int k = 1; k <= total + 1; k++) begin
            drive(sel, hold_valid && (k <= total), 4'($urandom_range(0, 15)));
            checkOutput($sformatf("dut%0d op%0d k%0d", sel, op, k), obs(sel),
                        model(op, k, s, st, tu));
            if (k <= total) tick();
        end
    endtask

    // At most one IB driver on either instance, every cycle.
    always @(negedge MainClock) begin
        if (inv_en) begin
            checks++;
            assert (($countones({sif.EnableA, sif.EnableAlu, sif.EnableIn}) <= 1) === 1'b1)
            else begin
                failures++;
                $error("[TB] FAIL single_driver dut0 observed=%b expected=onehot0",
                       {sif.EnableA, sif.EnableAlu, sif.EnableIn});
            end
            checks++;
            assert (($countones({sif2.EnableA, sif2.EnableAlu, sif2.EnableIn}) <= 1) === 1'b1)
            else begin
                failures++;
                $error("[TB] FAIL single_driver dut1 observed=%b expected=onehot0",
                       {sif2.EnableA, sif2.EnableAlu, sif2.EnableIn});
            end
        end
    end

    initial begin
        int op;
        MainReset = 1'b1;
        drive(0, 1'b0, 4'd0);
        drive(1, 1'b0, 4'd0);
        tick();
        tick();
        checkOutput("reset_dut0", obs(0), IDLE_RST);
        checkOutput("reset_dut1", obs(1), IDLE_RST);
        MainReset = 1'b0;
        tick();
        checkOutput("post_reset_dut0", obs(0), IDLE_RST);
        inv_en = 1'b1;

        $display("[TB] directed LDA, SUB, ADD, illegal 12");
        applyStimulus(0, 1, 1, 1, 1, 1'b0);
        applyStimulus(0, 4, 1, 1, 1, 1'b0);
        applyStimulus(0, 3, 1, 1, 1, 1'b0);
        applyStimulus(0, 12, 1, 1, 1, 1'b0);

        $display("[TB] OUTA with SETUP=2 STROBE=3");
        applyStimulus(1, 6, 2, 3, 1, 1'b0);

        $display("[TB] back-to-back with InstrValid held");
        for (int r = 0; r < 2; r++) begin
            applyStimulus(0, 1, 1, 1, 1, 1'b1);
            applyStimulus(0, 2, 1, 1, 1, 1'b1);
            applyStimulus(0, 5, 1, 1, 1, 1'b1);
            applyStimulus(0, 7, 1, 1, 1, 1'b1);
        end

        $display("[TB] random opcodes");
        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 15));
            applyStimulus(0, op, 1, 1, 1, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++) begin
            op = int'($urandom_range(0, 15));
            applyStimulus(1, op, 2, 3, 1, 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during ACC strobe");
        drive(0, 1'b1, 4'd5);
        tick();
        drive(0, 1'b0, 4'd0);
        checkOutput("acc_k1", obs(0), model(5, 1, 1, 1, 1));
        tick();
        checkOutput("acc_k2_strobe", obs(0), model(5, 2, 1, 1, 1));
        MainReset = 1'b1;
        tick();
        checkOutput("acc_cut_dut0", obs(0), IDLE_RST);
        checkOutput("acc_cut_dut1", obs(1), IDLE_RST);
        MainReset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("acc_after_reset c%0d", i), obs(0), IDLE_RST);
        end

        $display("[TB] reset with InstrValid");
        MainReset = 1'b1;
        drive(0, 1'b1, 4'd1);
        tick();
        MainReset = 1'b0;
        drive(0, 1'b0, 4'd0);
        checkOutput("rst_valid_c0", obs(0), IDLE_RST);
        tick();
        checkOutput("rst_valid_c1", obs(0), IDLE_RST);
        tick();
        checkOutput("rst_valid_c2", obs(0), IDLE_RST);

        inv_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
